modaddsub_seq: RTL and testbench

- Limb-serial modular add/subtract sequencer for the ECC field arithmetic.
- Computes (a+b) mod p or (a-b) mod p on NLIMB×64-bit operands.
- Time-shares one 64-bit simple_adder and one 64-bit simple_subtractor over two passes: raw op, then correction.
- Called by the point-arithmetic controller via a start/done handshake.

---
 rtl/modaddsub_pkg.sv | 26 ++
 rtl/addsub_limb_alu.sv | 37 +++
 rtl/simple_adder.sv | 14 +
 rtl/simple_subtractor.sv | 15 +
 rtl/modaddsub_seq.sv | 185 ++++++++++++++++++
 tb/tb_modaddsub_seq.sv | 255 +++++++++++++++++++++++++
 6 files changed

// File: rtl/modaddsub_pkg.sv
// Shared types and constants for the limb-serial modular add/subtract sequencer.
package modaddsub_pkg;

  localparam int unsigned LIMB_W        = 64;
  localparam int unsigned NLIMB_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    P1   = 2'd1,
    P2   = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // NIST P-256 field prime
  localparam logic [255:0] P256 =
    256'hffffffff_00000001_00000000_00000000_00000000_ffffffff_ffffffff_ffffffff;

  // Limb index width; a single limb still gets a 1-bit index
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/addsub_limb_alu.sv
// Combinational limb ALU: one adder and one subtractor, selected per pass.
module addsub_limb_alu
  import modaddsub_pkg::*;
(
  input  logic [LIMB_W-1:0] x,
  input  logic [LIMB_W-1:0] y,
  input  logic              cin,
  input  logic              sub,
  output logic [LIMB_W-1:0] z,
  output logic              cout
);

  logic [LIMB_W-1:0] sum;
  logic [LIMB_W-1:0] diff;
  logic              add_c;
  logic              sub_b;

  simple_adder u_add (
    .x    (x),
    .y    (y),
    .cin  (cin),
    .sum  (sum),
    .cout (add_c)
  );

  simple_subtractor u_sub (
    .x    (x),
    .y    (y),
    .bin  (cin),
    .diff (diff),
    .bout (sub_b)
  );

  assign z    = sub ? diff  : sum;
  assign cout = sub ? sub_b : add_c;

endmodule

// File: rtl/simple_adder.sv
// 64-bit adder with carry in/out.
module simple_adder
  import modaddsub_pkg::*;
(
  input  logic [LIMB_W-1:0] x,
  input  logic [LIMB_W-1:0] y,
  input  logic              cin,
  output logic [LIMB_W-1:0] sum,
  output logic              cout
);

  assign {cout, sum} = (LIMB_W+1)'(x) + (LIMB_W+1)'(y) + (LIMB_W+1)'(cin);

endmodule

// File: rtl/simple_subtractor.sv
// 64-bit subtractor with borrow in/out.
module simple_subtractor
  import modaddsub_pkg::*;
(
  input  logic [LIMB_W-1:0] x,
  input  logic [LIMB_W-1:0] y,
  input  logic              bin,
  output logic [LIMB_W-1:0] diff,
  output logic              bout
);

  // Bit LIMB_W of the widened difference is set exactly when x < y + bin
  assign {bout, diff} = (LIMB_W+1)'(x) - (LIMB_W+1)'(y) - (LIMB_W+1)'(bin);

endmodule

// File: rtl/modaddsub_seq.sv
// Limb-serial modular add/subtract sequencer: raw pass (P1) then correction
// pass (P2) through one shared limb ALU; fixed, data-independent latency.
// Optional macro MODADDSUB_ABORT_EN adds an abort input for P1/P2.
module modaddsub_seq
  import modaddsub_pkg::*;
#(
  parameter int unsigned NLIMB = NLIMB_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    op,
  input  logic [LIMB_W*NLIMB-1:0] a,
  input  logic [LIMB_W*NLIMB-1:0] b,
  input  logic [LIMB_W*NLIMB-1:0] p,
`ifdef MODADDSUB_ABORT_EN
  input  logic                    abort,
`endif
  output logic                    ready,
  output logic                    busy,
  output logic                    done,
  output logic [LIMB_W*NLIMB-1:0] result
);

  localparam int unsigned FW = LIMB_W * NLIMB;
  localparam int unsigned IW = idx_w(NLIMB);
  localparam logic [IW-1:0] IDX_LAST = IW'(NLIMB - 1);

  state_t          state;
  logic [IW-1:0]   idx;
  logic            carry;
  logic            c1;
  logic            c2;
  logic            fin;
  logic            op_r;
  logic [FW-1:0]   a_r;
  logic [FW-1:0]   b_r;
  logic [FW-1:0]   p_r;
  logic [FW-1:0]   s_r;
  logic [FW-1:0]   t_r;

  logic [LIMB_W-1:0] alu_x;
  logic [LIMB_W-1:0] alu_y;
  logic              alu_sub;
  logic [LIMB_W-1:0] alu_z;
  logic              alu_cout;
  logic [FW-1:0]     t_full_c;
  logic              sel_t_c;
  logic              kill_c;

  // Abort request, only meaningful while a pass is running
`ifdef MODADDSUB_ABORT_EN
  assign kill_c = abort;
`else
  assign kill_c = 1'b0;
`endif

  // Operand routing: P1 combines a/b with op, P2 applies p with the opposite op
  always_comb begin
    alu_x   = s_r[idx*LIMB_W +: LIMB_W];
    alu_y   = p_r[idx*LIMB_W +: LIMB_W];
    alu_sub = ~op_r;
    if (state == P1) begin
      alu_x   = a_r[idx*LIMB_W +: LIMB_W];
      alu_y   = b_r[idx*LIMB_W +: LIMB_W];
      alu_sub = op_r;
    end
  end

  addsub_limb_alu u_alu (
    .x    (alu_x),
    .y    (alu_y),
    .cin  (carry),
    .sub  (alu_sub),
    .z    (alu_z),
    .cout (alu_cout)
  );

  // Correction value including the limb being produced this cycle, and the
  // final pick between raw and corrected (alu_cout is c2 on the last P2 limb)
  always_comb begin
    t_full_c                          = t_r;
    t_full_c[idx*LIMB_W +: LIMB_W]    = alu_z;
    sel_t_c = (op_r == OP_ADD) ? (c1 | ~alu_cout) : c1;
  end

  // Sequencer state, datapath registers and registered handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      idx    <= '0;
      carry  <= 1'b0;
      c1     <= 1'b0;
      c2     <= 1'b0;
      fin    <= 1'b0;
      op_r   <= OP_ADD;
      a_r    <= '0;
      b_r    <= '0;
      p_r    <= '0;
      s_r    <= '0;
      t_r    <= '0;
      ready  <= 1'b1;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_r   <= a;
            b_r   <= b;
            p_r   <= p;
            op_r  <= op;
            idx   <= '0;
            carry <= 1'b0;
            ready <= 1'b0;
            busy  <= 1'b1;
            state <= P1;
          end
        end
        P1: begin
          if (kill_c) begin
            idx   <= '0;
            carry <= 1'b0;
            ready <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            s_r[idx*LIMB_W +: LIMB_W] <= alu_z;
            if (idx == IDX_LAST) begin
              c1    <= alu_cout;
              carry <= 1'b0;
              idx   <= '0;
              state <= P2;
            end else begin
              carry <= alu_cout;
              idx   <= idx + IW'(1);
            end
          end
        end
        P2: begin
          if (kill_c) begin
            idx   <= '0;
            carry <= 1'b0;
            ready <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            t_r[idx*LIMB_W +: LIMB_W] <= alu_z;
            if (idx == IDX_LAST) begin
              c2     <= alu_cout;
              carry  <= 1'b0;
              idx    <= '0;
              result <= sel_t_c ? t_full_c : s_r;
              busy   <= 1'b0;
              fin    <= 1'b0;
              state  <= DONE;
            end else begin
              carry <= alu_cout;
              idx   <= idx + IW'(1);
            end
          end
        end
        DONE: begin
          // Result settles on entry; the done pulse follows one cycle later
          if (!fin) begin
            fin  <= 1'b1;
            done <= 1'b1;
          end else begin
            fin   <= 1'b0;
            ready <= 1'b1;
            state <= IDLE;
          end
        end
        default: begin
          ready <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_modaddsub_seq.sv
// Self-checking bench for modaddsub_seq (NLIMB=4, 256-bit fields).
// Covers MODADDSUB_ABORT_EN when the macro is defined.
module tb_modaddsub_seq;
  import modaddsub_pkg::*;

  localparam int unsigned NL = 4;
  localparam int unsigned W  = 64 * NL;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] p;
  logic         ready;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
`ifdef MODADDSUB_ABORT_EN
  logic         abort;
`endif

  int tests;
  int fails;
  int cyc_now;
  int last_done_cyc;

  modaddsub_seq #(.NLIMB(NL)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .p      (p),
`ifdef MODADDSUB_ABORT_EN
    .abort  (abort),
`endif
    .ready  (ready),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Free-running cycle counter, advanced on every sampling edge
  initial cyc_now = 0;
  always @(negedge clk) cyc_now = cyc_now + 1;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    tests = tests + 1;
    assert (obs === exp) else begin
      fails = fails + 1;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: plain modular arithmetic on wide integers
  function automatic logic [W-1:0] ref_model(input logic o, input logic [W-1:0] av,
                                             input logic [W-1:0] bv, input logic [W-1:0] pv);
    logic [W:0] x;
    if (o == OP_ADD) begin
      x = {1'b0, av} + {1'b0, bv};
      if (x >= {1'b0, pv}) x = x - {1'b0, pv};
    end else begin
      if (av >= bv) x = {1'b0, av} - {1'b0, bv};
      else          x = {1'b0, av} + {1'b0, pv} - {1'b0, bv};
    end
    return x[W-1:0];
  endfunction

  function automatic logic [W-1:0] rnd_w();
    logic [W-1:0] v;
    for (int i = 0; i < int'(W / 32); i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Drive one operation from a negedge with ready=1; returns at the negedge
  // after the done pulse. repulse re-asserts start with other data in P1.
  task automatic run_op(input logic o, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic [W-1:0] pv, input bit repulse, input string tag);
    logic [W-1:0] exp;
    int cyc;
    int busy_n;
    int rdy_n;
    bit seen;
    exp   = ref_model(o, av, bv, pv);
    op    = o;
    a     = av;
    b     = bv;
    p     = pv;
    start = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    cyc    = 1;
    busy_n = busy ? 1 : 0;
    rdy_n  = ready ? 1 : 0;
    seen   = done;
    // Inputs changing after acceptance must not matter
    a  = rnd_w();
    b  = rnd_w();
    op = ~o;
    while (!seen && cyc < 40) begin
      if (repulse && cyc == 2) start = 1'b1;
      @(negedge clk);
      start  = 1'b0;
      cyc    = cyc + 1;
      busy_n = busy_n + (busy ? 1 : 0);
      rdy_n  = rdy_n + (ready ? 1 : 0);
      seen   = done;
    end
    last_done_cyc = cyc_now;
    chk({tag, "_done_seen"}, W'(seen), W'(1'b1));
    chk({tag, "_latency"}, W'(cyc), W'(10));
    chk({tag, "_result"}, result, exp);
    chk({tag, "_busy_cycles"}, W'(busy_n), W'(8));
    chk({tag, "_ready_low"}, W'(rdy_n), W'(0));
    @(negedge clk);
    chk({tag, "_done_pulse"}, W'(done), W'(1'b0));
    chk({tag, "_ready_back"}, W'(ready), W'(1'b1));
    chk({tag, "_result_hold"}, result, exp);
  endtask

  initial begin
    logic [W-1:0] pm;
    logic [W-1:0] pr;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic [W-1:0] held;
    int d1;
    int n_done;
    tests = 0;
    fails = 0;
    last_done_cyc = 0;
    pm    = P256;
    rst_n = 1'b0;
    start = 1'b0;
    op    = OP_ADD;
    a     = '0;
    b     = '0;
    p     = pm;
`ifdef MODADDSUB_ABORT_EN
    abort = 1'b0;
`endif
    #12;
    chk("rst_ready", W'(ready), W'(1'b1));
    chk("rst_busy", W'(busy), W'(1'b0));
    chk("rst_done", W'(done), W'(1'b0));
    chk("rst_result", result, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed corner cases
    run_op(OP_ADD, W'(1), W'(2), pm, 1'b0, "add_1_2");
    run_op(OP_ADD, pm - W'(1), W'(1), pm, 1'b0, "add_pm1_1");
    run_op(OP_ADD, pm - W'(1), pm - W'(1), pm, 1'b0, "add_pm1_pm1");
    run_op(OP_SUB, W'(1), W'(2), pm, 1'b0, "sub_1_2");
    run_op(OP_SUB, W'(5), W'(5), pm, 1'b0, "sub_5_5");
    run_op(OP_SUB, W'(0), pm - W'(1), pm, 1'b0, "sub_0_pm1");

    // start re-pulsed during P1 is ignored; exactly one done
    run_op(OP_ADD, W'(7), W'(9), pm, 1'b1, "repulse");
    n_done = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) n_done = n_done + 1;
    end
    chk("repulse_extra_done", W'(n_done), W'(0));

    // Back-to-back operations: done pulses 11 cycles apart
    run_op(OP_SUB, W'(3), W'(10), pm, 1'b0, "b2b_a");
    d1 = last_done_cyc;
    run_op(OP_ADD, pm - W'(3), W'(10), pm, 1'b0, "b2b_b");
    chk("b2b_gap", W'(last_done_cyc - d1), W'(11));

    // Asynchronous reset in P2 aborts without a done pulse
    op    = OP_ADD;
    a     = W'(100);
    b     = W'(200);
    p     = pm;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    chk("p2_busy_before_rst", W'(busy), W'(1'b1));
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_ready", W'(ready), W'(1'b1));
    chk("midrst_busy", W'(busy), W'(1'b0));
    chk("midrst_done", W'(done), W'(1'b0));
    chk("midrst_result", result, '0);
    n_done = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done) n_done = n_done + 1;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done) n_done = n_done + 1;
    end
    chk("midrst_no_done", W'(n_done), W'(0));
    run_op(OP_SUB, W'(4), W'(9), pm, 1'b0, "after_rst");

`ifdef MODADDSUB_ABORT_EN
    // abort in P1: back to IDLE next cycle, no done, result kept
    held  = result;
    op    = OP_ADD;
    a     = W'(11);
    b     = W'(22);
    p     = pm;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_ready", W'(ready), W'(1'b1));
    chk("abort_busy", W'(busy), W'(1'b0));
    n_done = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) n_done = n_done + 1;
    end
    chk("abort_no_done", W'(n_done), W'(0));
    chk("abort_result_kept", result, held);
    run_op(OP_ADD, W'(11), W'(22), pm, 1'b0, "after_abort");
`else
    held = '0;
`endif

    // Randomized operands, P-256 and random odd moduli above 2^(W-1)
    for (int k = 0; k < 16; k++) begin
      if (k < 8) pr = pm;
      else begin
        pr        = rnd_w();
        pr[W-1]   = 1'b1;
        pr[0]     = 1'b1;
      end
      ra = rnd_w() % pr;
      rb = rnd_w() % pr;
      if (k % 5 == 0) rb = pr - W'(1);
      run_op(logic'($urandom_range(0, 1)), ra, rb, pr, 1'b0, $sformatf("rnd%0d", k));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
